// File: rtl/universal_counter_n.sv
// Parametrised up/down counter with programmable modulus, clamped parallel load,
// wrap or saturate at the range ends, cascade enable chain and a registered compare match.
module universal_counter_n #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             count,
    input  logic             up_dn,
    input  logic             cas_in,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             cmp_match
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             at_end;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] next_q;
    logic             next_wrap;

    assign step    = count & cas_in;
    assign at_max  = (q == MAX);
    assign at_zero = (q == '0);
    assign at_end  = up_dn ? at_max : at_zero;
    assign tc      = step & at_end;

    // Range-end behaviour stays inside 0..MAX, so modulus is honoured even when MODULUS < 2**WIDTH.
    always_comb begin
        step_q = q;
        if (up_dn) begin
            if (at_max)
                step_q = SATURATE ? MAX : '0;
            else
                step_q = q + WIDTH'(1);
        end else begin
            if (at_zero)
                step_q = SATURATE ? '0 : MAX;
            else
                step_q = q - WIDTH'(1);
        end
    end

    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        if (sync_clr) begin
            next_q = '0;
        end else if (load) begin
            next_q = (din > MAX) ? MAX : din;
        end else if (step) begin
            next_q    = step_q;
            next_wrap = at_end;
        end
    end

    // cmp_match compares the value q is about to take, so it lines up with q itself.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q         <= '0;
            wrap      <= 1'b0;
            cmp_match <= 1'b0;
        end else begin
            q         <= next_q;
            wrap      <= next_wrap;
            cmp_match <= (next_q == cmp_val);
        end
    end

endmodule

// File: tb/tb_universal_counter_n.sv
// Directed bench: wrap and saturate instances (WIDTH=4, MODULUS=10) driven in parallel,
// plus a two-stage MODULUS=16 cascade.
module tb_universal_counter_n;

    logic       clk = 1'b0;
    logic       clear;
    logic       sync_clr;
    logic       load;
    logic [3:0] din;
    logic       count;
    logic       up_dn;
    logic [3:0] cmp_val;
    logic       cas_one;

    logic [3:0] a_q, s_q;
    logic       a_tc, s_tc, a_wrap, s_wrap, a_cmp, s_cmp;

    logic       c_count;
    logic       c_zero;
    logic [3:0] c_zero4;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_cmp, hi_cmp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    universal_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clear(clear), .sync_clr(sync_clr), .load(load), .din(din),
        .count(count), .up_dn(up_dn), .cas_in(cas_one), .cmp_val(cmp_val),
        .q(a_q), .tc(a_tc), .wrap(a_wrap), .cmp_match(a_cmp)
    );

    universal_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clear(clear), .sync_clr(sync_clr), .load(load), .din(din),
        .count(count), .up_dn(up_dn), .cas_in(cas_one), .cmp_val(cmp_val),
        .q(s_q), .tc(s_tc), .wrap(s_wrap), .cmp_match(s_cmp)
    );

    universal_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_lo (
        .clk(clk), .clear(clear), .sync_clr(c_zero), .load(c_zero), .din(c_zero4),
        .count(c_count), .up_dn(cas_one), .cas_in(cas_one), .cmp_val(c_zero4),
        .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .cmp_match(lo_cmp)
    );

    universal_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_hi (
        .clk(clk), .clear(clear), .sync_clr(c_zero), .load(c_zero), .din(c_zero4),
        .count(c_count), .up_dn(cas_one), .cas_in(lo_tc), .cmp_val(c_zero4),
        .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .cmp_match(hi_cmp)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_a, exp_s, cnt;
        clear    = 1'b1;
        sync_clr = 1'b0;
        load     = 1'b0;
        din      = 4'd0;
        count    = 1'b0;
        up_dn    = 1'b1;
        cmp_val  = 4'd7;
        cas_one  = 1'b1;
        c_count  = 1'b0;
        c_zero   = 1'b0;
        c_zero4  = 4'd0;

        #12;
        checkOutput("reset_q", a_q, 0);
        checkOutput("reset_wrap", a_wrap, 0);
        checkOutput("reset_cmp", a_cmp, 0);
        checkOutput("reset_sat_q", s_q, 0);
        clear = 1'b0;

        // Count up 12 edges: wrap instance rolls 9->0, saturate instance sticks at 9.
        count = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus();
            exp_a = i % 10;
            exp_s = (i > 9) ? 9 : i;
            checkOutput($sformatf("up_q_%0d", i), a_q, exp_a);
            checkOutput($sformatf("up_wrap_%0d", i), a_wrap, (i == 10));
            checkOutput($sformatf("up_tc_%0d", i), a_tc, (exp_a == 9));
            checkOutput($sformatf("up_cmp_%0d", i), a_cmp, (exp_a == 7));
            checkOutput($sformatf("up_sat_q_%0d", i), s_q, exp_s);
            checkOutput($sformatf("up_sat_wrap_%0d", i), s_wrap, (i >= 10));
            checkOutput($sformatf("up_sat_tc_%0d", i), s_tc, (exp_s == 9));
        end

        sync_clr = 1'b1;
        applyStimulus();
        checkOutput("sclr_q", a_q, 0);
        checkOutput("sclr_sat_q", s_q, 0);
        checkOutput("sclr_sat_wrap", s_wrap, 0);
        sync_clr = 1'b0;

        up_dn = 1'b0;
        applyStimulus();
        checkOutput("dn1_q", a_q, 9);
        checkOutput("dn1_wrap", a_wrap, 1);
        checkOutput("dn1_sat_q", s_q, 0);
        checkOutput("dn1_sat_wrap", s_wrap, 1);
        applyStimulus();
        checkOutput("dn2_q", a_q, 8);
        checkOutput("dn2_wrap", a_wrap, 0);
        checkOutput("dn2_sat_wrap", s_wrap, 1);
        applyStimulus();
        checkOutput("dn3_q", a_q, 7);
        checkOutput("dn3_cmp", a_cmp, 1);
        checkOutput("dn3_tc", a_tc, 0);
        checkOutput("dn3_sat_q", s_q, 0);
        checkOutput("dn3_sat_wrap", s_wrap, 1);
        checkOutput("dn3_sat_tc", s_tc, 1);
        count = 1'b0;
        applyStimulus();
        checkOutput("hold_q", a_q, 7);
        checkOutput("hold_sat_wrap", s_wrap, 0);
        checkOutput("hold_sat_tc", s_tc, 0);

        // Loads: clamp above MAX, load beats count, sync_clr beats load.
        up_dn = 1'b1;
        load  = 1'b1;
        din   = 4'hE;
        applyStimulus();
        checkOutput("ld_clampE_q", a_q, 9);
        checkOutput("ld_clampE_sat_q", s_q, 9);
        checkOutput("ld_clampE_cmp", a_cmp, 0);
        count = 1'b1;
        din   = 4'hA;
        applyStimulus();
        checkOutput("ld_clampA_q", a_q, 9);
        checkOutput("ld_clampA_wrap", a_wrap, 0);
        din = 4'h9;
        applyStimulus();
        checkOutput("ld_9_q", a_q, 9);
        checkOutput("ld_tc_ignores_load", a_tc, 1);
        sync_clr = 1'b1;
        din      = 4'hE;
        applyStimulus();
        checkOutput("ld_sclr_q", a_q, 0);
        checkOutput("ld_sclr_sat_q", s_q, 0);
        sync_clr = 1'b0;
        din      = 4'h3;
        applyStimulus();
        checkOutput("ld_cnt_q", a_q, 3);
        checkOutput("ld_cnt_tc", a_tc, 0);
        load = 1'b0;

        // Async clear between edges at q=5.
        cmp_val = 4'd5;
        applyStimulus();
        checkOutput("pre_clr_q4", a_q, 4);
        applyStimulus();
        checkOutput("pre_clr_q5", a_q, 5);
        checkOutput("pre_clr_cmp", a_cmp, 1);
        #3;
        clear = 1'b1;
        #1;
        checkOutput("aclr_q", a_q, 0);
        checkOutput("aclr_wrap", a_wrap, 0);
        checkOutput("aclr_cmp", a_cmp, 0);
        applyStimulus();
        checkOutput("aclr_held_q", a_q, 0);
        #2;
        clear = 1'b0;
        applyStimulus();
        checkOutput("aclr_resume_q", a_q, 1);
        count = 1'b0;

        // Cascade of two mod-16 stages counting 300 edges.
        c_count = 1'b1;
        cnt     = 0;
        for (int k = 1; k <= 300; k++) begin
            applyStimulus();
            cnt = k % 256;
            checkOutput($sformatf("casc_%0d", k), {24'd0, hi_q, lo_q}, cnt);
        end
        checkOutput("casc_final", {24'd0, hi_q, lo_q}, 44);
        c_count = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
